mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: ports `clk` and `rst`; `rst` is sampled only on the rising edge of `clk`.
REQ-002 `clk` SHALL be: input, 1 bit, rising-edge system clock.
REQ-003 `rst` SHALL be: input, 1 bit, synchronous active-high reset.
REQ-004 `funct` SHALL be: input, `FUNCT_BUS`, operation select; valid codes are `FUNCT_MULT`, `FUNCT_MULTU`, `FUNCT_DIV`, `FUNCT_DIVU`.
REQ-005 `start` SHALL be: input, 1 bit, request from EX stage, qualified by a valid `funct`.
REQ-006 `flush` SHALL be: input, 1 bit, pipeline flush, aborts any operation.
REQ-007 `operand_1` SHALL be: input, `DATA_BUS`, multiplicand / dividend.
REQ-008 `operand_2` SHALL be: input, `DATA_BUS`, multiplier / divisor.
REQ-009 `busy` SHALL be: output, 1 bit, stall request to the pipeline.
REQ-010 `done` SHALL be: output, 1 bit, one-cycle result-valid pulse.
REQ-011 `hi` SHALL be: output, `DATA_BUS`; holds the product upper word or the remainder.
REQ-012 `lo` SHALL be: output, `DATA_BUS`; holds the product lower word or the quotient.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-014 Acceptance: in IDLE, `start`=1 with a valid `funct` and `flush`=0 SHALL latch the operands and `funct` at edge E0 and go to BUSY with iteration counter = 0.
REQ-015 In IDLE, `start` with an invalid `funct` SHALL be ignored: no state change, and `hi`/`lo` unchanged.
REQ-016 BUSY SHALL perform one radix-2 iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) on 32-bit magnitudes, using a 64-bit working register.
REQ-017 After 32 iterations (edge E32), BUSY SHALL go to DONE and register `hi`/`lo` at that edge.
REQ-018 DONE SHALL last exactly one cycle: `done`=1 in that cycle, and the FSM returns to IDLE at E33.
REQ-019 `hi`/`lo` SHALL hold their value until the next result is written.
REQ-020 `busy` SHALL be 1 in BUSY, and combinationally 1 in IDLE when an accept condition per REQ-014 is present; it SHALL be 0 otherwise, including in DONE.
REQ-021 `start` in BUSY or DONE SHALL be ignored; a new op may be accepted only from IDLE, i.e. from the cycle after DONE.
REQ-022 Signed ops (MULT, DIV) SHALL take magnitudes of both operands; the result sign is applied at E32.
REQ-023 MULT SHALL negate the 64-bit product when operand signs differ.
REQ-024 DIV SHALL give a quotient negative when operand signs differ, and a remainder with the sign of the dividend.
REQ-025 Magnitude of 32'h80000000 SHALL be treated as unsigned 2^31.
REQ-026 DIV 32'h80000000 / 32'hFFFFFFFF SHALL yield `lo`=32'h80000000, `hi`=0.
REQ-027 MULTU and DIVU SHALL treat operands as unsigned with no sign fix-up.
REQ-028 Divide by zero (DIV/DIVU with `operand_2`=0) SHALL go IDLE->DONE directly at E0 with `hi`=`operand_1` and `lo`=32'hFFFFFFFF; `done` is asserted in the next cycle.
REQ-029 `flush`=1 in any state SHALL force IDLE at the next edge, leave `hi`/`lo` unchanged, and produce no `done` pulse.
REQ-030 `flush` SHALL take priority over `start` in the same cycle.
REQ-031 Operand inputs SHALL be sampled only at acceptance; changes during BUSY SHALL have no effect.

Reset
REQ-032 `rst`=1 at a rising edge SHALL force state IDLE, counter 0, working register 0, `hi`=0, `lo`=0.
REQ-033 Out of reset, `busy`=0 and `done`=0.
REQ-034 `rst` SHALL override `flush` and `start`.
REQ-035 `rst` asserted mid-operation SHALL abandon the operation with no `done` pulse.

Verification
REQ-036 MULT, `operand_1`=32'hFFFFFFFD (-3), `operand_2`=7 -> `done` in cycle 33 after accept, `hi`=32'hFFFFFFFF, `lo`=32'hFFFFFFEB; `busy`=1 from the accept cycle through cycle 32.
REQ-037 MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> `hi`=32'hFFFFFFFE, `lo`=32'h00000001.
REQ-038 DIV -7/2 -> `lo`=32'hFFFFFFFD, `hi`=32'hFFFFFFFF. DIV 32'h80000000/32'hFFFFFFFF -> `lo`=32'h80000000, `hi`=0.
REQ-039 DIVU 5/0 -> `done` one cycle after accept, `hi`=5, `lo`=32'hFFFFFFFF, no BUSY cycles.
REQ-040 Prior result `hi`=1/`lo`=2, start MULTU 3x4, then `flush` at iteration 10 -> IDLE next cycle, no `done`, `hi`=1/`lo`=2 retained; a second `start` during BUSY is ignored.
REQ-041 `rst` asserted at iteration 20 of DIVU -> `hi`=`lo`=0, IDLE, `busy`=0; a new MULTU 6x7 accepted afterwards -> `lo`=42, `hi`=0.

Source files
------------

// File: rtl/mult_div.sv
// Iterative radix-2 multiply/divide unit for the EX stage.
// Signed ops work on magnitudes and apply the sign on the final iteration.
package mult_div_pkg;
    localparam int DATA_W  = 32;
    localparam int FUNCT_W = 6;

    typedef logic [DATA_W-1:0]  DATA_BUS;
    typedef logic [FUNCT_W-1:0] FUNCT_BUS;

    localparam FUNCT_BUS FUNCT_MULT  = 6'h18;
    localparam FUNCT_BUS FUNCT_MULTU = 6'h19;
    localparam FUNCT_BUS FUNCT_DIV   = 6'h1A;
    localparam FUNCT_BUS FUNCT_DIVU  = 6'h1B;
endpackage

module mult_div
    import mult_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  FUNCT_BUS funct,
    input  logic     start,
    input  logic     flush,
    input  DATA_BUS  operand_1,
    input  DATA_BUS  operand_2,
    output logic     busy,
    output logic     done,
    output DATA_BUS  hi,
    output DATA_BUS  lo
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  cnt;
    logic [63:0] acc;
    DATA_BUS     b_mag;
    logic        op_div;
    logic        neg_q;
    logic        neg_r;

    logic        funct_ok;
    logic        div_in;
    logic        sgn_in;
    logic        accept;
    logic        div0;
    DATA_BUS     a_mag_in;
    DATA_BUS     b_mag_in;

    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;
    logic [32:0] rem_sh;
    logic [32:0] rem_sub;
    logic        rem_ge;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;
    logic [63:0] prod;
    DATA_BUS     quo;
    DATA_BUS     rem;
    DATA_BUS     res_hi;
    DATA_BUS     res_lo;

    assign funct_ok = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
                      (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    assign div_in   = (funct == FUNCT_DIV) || (funct == FUNCT_DIVU);
    assign sgn_in   = (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
    assign accept   = (state == IDLE) && start && funct_ok && !flush;
    assign div0     = div_in && (operand_2 == '0);

    // 32'h80000000 negates to itself, which is 2^31 read unsigned.
    assign a_mag_in = (sgn_in && operand_1[31]) ? -operand_1 : operand_1;
    assign b_mag_in = (sgn_in && operand_2[31]) ? -operand_2 : operand_2;

    assign mul_sum = {1'b0, acc[63:32]} +
                     (acc[0] ? {1'b0, b_mag} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

    // Partial remainder can reach 33 bits after the shift.
    assign rem_sh  = acc[63:31];
    assign rem_ge  = rem_sh >= {1'b0, b_mag};
    assign rem_sub = rem_sh - {1'b0, b_mag};
    assign div_nxt = rem_ge ? {rem_sub[31:0], acc[30:0], 1'b1}
                            : {acc[62:0], 1'b0};

    assign acc_nxt = op_div ? div_nxt : mul_nxt;
    assign prod    = neg_q ? -acc_nxt : acc_nxt;
    assign quo     = acc_nxt[31:0];
    assign rem     = acc_nxt[63:32];
    assign res_hi  = op_div ? (neg_r ? -rem : rem) : prod[63:32];
    assign res_lo  = op_div ? (neg_q ? -quo : quo) : prod[31:0];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div0 ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == 6'd31) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == BUSY) || accept;
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            b_mag  <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state <= (flush && state != IDLE) ? IDLE : state_nxt;
            if (accept) begin
                cnt    <= '0;
                acc    <= {32'b0, a_mag_in};
                b_mag  <= b_mag_in;
                op_div <= div_in;
                neg_q  <= sgn_in && (operand_1[31] ^ operand_2[31]);
                neg_r  <= sgn_in && operand_1[31];
                if (div0) begin
                    hi <= operand_1;
                    lo <= '1;
                end
            end else if (state == BUSY && !flush) begin
                acc <= acc_nxt;
                cnt <= cnt + 6'd1;
                if (cnt == 6'd31) begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Scoreboard bench for mult_div: stimulus pushes expected hi/lo,
// a monitor pops and compares on every done pulse.
module tb_mult_div;
    import mult_div_pkg::*;

    logic     clk = 1'b0;
    logic     rst;
    FUNCT_BUS funct;
    logic     start;
    logic     flush;
    DATA_BUS  operand_1;
    DATA_BUS  operand_2;
    logic     busy;
    logic     done;
    DATA_BUS  hi;
    DATA_BUS  lo;

    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    logic [63:0] exp_q[$];

    mult_div dut (
        .clk       (clk),
        .rst       (rst),
        .funct     (funct),
        .start     (start),
        .flush     (flush),
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got hi=%h lo=%h want none",
                         hi, lo);
            end else begin
                chk("result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input FUNCT_BUS f, input DATA_BUS a,
                         input DATA_BUS b);
        funct     = f;
        operand_1 = a;
        operand_2 = b;
        start     = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int prev;
        bit seen;
        prev = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != prev) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL %s_timeout: got no done want done", name);
        end
        tick();
    endtask

    task automatic run_op(input string name, input FUNCT_BUS f,
                          input DATA_BUS a, input DATA_BUS b,
                          input DATA_BUS eh, input DATA_BUS el);
        exp_q.push_back({eh, el});
        drive(f, a, b);
        tick();
        start = 1'b0;
        operand_1 = ~a;
        operand_2 = ~b;
        wait_done(name, 40);
    endtask

    initial begin
        int nbusy;
        rst = 1'b1;
        funct = '0;
        start = 1'b0;
        flush = 1'b0;
        operand_1 = '0;
        operand_2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        #2;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
        tick();

        exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFEB});
        drive(FUNCT_MULT, 32'hFFFFFFFD, 32'd7);
        #1;
        chk("busy_accept", {63'd0, busy}, 64'd1);
        tick();
        start = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            if (busy) nbusy++;
            tick();
        end
        chk("mult_latency", nbusy, 32);
        chk("busy_in_done", {62'd0, busy, done}, 64'd1);
        tick();

        run_op("multu_max", FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001);
        run_op("div_neg7_2", FUNCT_DIV, 32'hFFFFFFF9, 32'd2,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_min_m1", FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h0, 32'h80000000);
        run_op("div_7_neg2", FUNCT_DIV, 32'd7, 32'hFFFFFFFE,
               32'd1, 32'hFFFFFFFD);
        run_op("divu_big", FUNCT_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE,
               32'd1, 32'd1);
        run_op("divu_10", FUNCT_DIVU, 32'hFFFFFFFF, 32'd10,
               32'd5, 32'h19999999);
        run_op("mult_m1_m1", FUNCT_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'd0, 32'd1);
        run_op("mult_min_min", FUNCT_MULT, 32'h80000000, 32'h80000000,
               32'h40000000, 32'd0);

        exp_q.push_back({32'd5, 32'hFFFFFFFF});
        drive(FUNCT_DIVU, 32'd5, 32'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("div0_latency", {63'd0, done}, 64'd1);
        tick();

        drive(6'h00, 32'd9, 32'd9);
        #1;
        chk("bad_funct_busy", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        chk("bad_funct_hilo", {hi, lo}, {32'd5, 32'hFFFFFFFF});

        run_op("prior", FUNCT_MULTU, 32'd2, 32'h80000001,
               32'd1, 32'd2);
        drive(FUNCT_MULTU, 32'd3, 32'd4);
        tick();
        start = 1'b0;
        repeat (5) tick();
        drive(FUNCT_MULTU, 32'd8, 32'd8);
        tick();
        start = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {63'd0, busy}, 64'd0);
        repeat (40) tick();
        chk("flush_hilo", {hi, lo}, {32'd1, 32'd2});

        drive(FUNCT_MULTU, 32'd5, 32'd5);
        flush = 1'b1;
        #1;
        chk("flush_prio_busy", {63'd0, busy}, 64'd0);
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_prio_idle", {63'd0, busy}, 64'd0);
        repeat (40) tick();

        drive(FUNCT_DIVU, 32'd100, 32'd7);
        tick();
        start = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        repeat (40) tick();
        run_op("multu_6x7", FUNCT_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
